// File: rtl/lsu_mem_stage.sv
// Load/store unit in front of DMEM: accepts one EX request at a time, checks alignment,
// drives the DMEM access and returns a one-cycle response. Define LSU_MISALIGN_SPLIT_EN for byte-serial misaligned access.
module lsu_mem_stage #(
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_load,
    input  logic            req_store,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [RD_W-1:0] req_rd,
    output logic            resp_valid,
    output logic            resp_is_load,
    output logic [RD_W-1:0] resp_rd,
    output logic [31:0]     resp_data,
    output logic            misalign_exc,
    output logic [31:0]     exc_addr,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic            dmem_sign_extend,
    output logic [1:0]      dmem_size,
    output logic [31:0]     dmem_addr,
    output logic [31:0]     dmem_wdata,
    input  logic [31:0]     dmem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              load_q, load_d;
    logic              uns_q, uns_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              exc_q, exc_d;
    logic              split_q, split_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       data_q, data_d;

    logic              accept;
    logic              misaligned;
    logic [1:0]        req_size_n;
    logic [1:0]        last_idx;
    logic [31:0]       asm_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            exc_q   <= 1'b0;
            split_q <= 1'b0;
            idx_q   <= 2'b00;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            exc_q   <= exc_d;
            split_q <= split_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // Size 11 is folded to word at acceptance so the rest of the FSM sees only 00/01/10.
    assign req_size_n = (req_size == 2'b11) ? 2'b10 : req_size;
    assign misaligned = ((req_size_n == 2'b01) && req_addr[0]) ||
                        ((req_size_n == 2'b10) && (req_addr[1:0] != 2'b00));
    assign req_ready  = (state_q == IDLE) && !rst;
    assign accept     = req_valid && req_ready && (req_load || req_store);
    assign last_idx   = (size_q == 2'b01) ? 2'd1 : 2'd3;

    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        uns_d    = uns_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        exc_d    = exc_q;
        split_d  = split_q;
        idx_d    = idx_q;
        data_d   = data_q;
        asm_data = data_q;
        asm_data[{idx_q, 3'b000} +: 8] = dmem_rdata[7:0];
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_d  = req_load;
                    uns_d   = req_unsigned;
                    size_d  = req_size_n;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    idx_d   = 2'b00;
                    data_d  = '0;
                    exc_d   = 1'b0;
                    split_d = 1'b0;
                    state_d = ISSUE;
                    if (misaligned) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        split_d = 1'b1;
`else
                        exc_d   = 1'b1;
                        state_d = DONE;
`endif
                    end
                end
            end
            ISSUE: begin
                if (load_q) begin
                    state_d = WAIT;
                end else if (split_q && (idx_q != last_idx)) begin
                    idx_d = idx_q + 2'd1;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (!split_q) begin
                    data_d  = dmem_rdata;
                    state_d = DONE;
                end else if (idx_q != last_idx) begin
                    data_d  = asm_data;
                    idx_d   = idx_q + 2'd1;
                    state_d = ISSUE;
                end else begin
                    // Bytes were fetched unextended; apply the half-word extension once assembled.
                    data_d  = (size_q == 2'b01) ?
                              {{16{!uns_q && asm_data[15]}}, asm_data[15:0]} : asm_data;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        resp_valid       = 1'b0;
        resp_is_load     = 1'b0;
        resp_rd          = '0;
        resp_data        = '0;
        misalign_exc     = 1'b0;
        exc_addr         = '0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_sign_extend = 1'b0;
        dmem_size        = 2'b00;
        dmem_addr        = '0;
        dmem_wdata       = '0;
        if (!rst && (state_q == DONE)) begin
            resp_valid   = 1'b1;
            resp_is_load = load_q;
            resp_rd      = rd_q;
            resp_data    = data_q;
            misalign_exc = exc_q;
            exc_addr     = exc_q ? addr_q : '0;
        end
        if (!rst && (state_q == ISSUE)) begin
            dmem_read        = load_q;
            dmem_write       = !load_q;
            dmem_sign_extend = split_q ? 1'b0 : !uns_q;
            dmem_size        = split_q ? 2'b00 : size_q;
            dmem_addr        = addr_q + {30'b0, idx_q};
            dmem_wdata       = split_q ? {24'b0, wdata_q[{idx_q, 3'b000} +: 8]} : wdata_q;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage with a byte-addressed DMEM model behind it.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_is_load, misalign_exc;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data, exc_addr;
    logic        dmem_read, dmem_write, dmem_sign_extend;
    logic [1:0]  dmem_size;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = 32'h0;

    int total = 0;
    int bad   = 0;

    lsu_mem_stage #(.RD_W(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_is_load(resp_is_load), .resp_rd(resp_rd),
        .resp_data(resp_data), .misalign_exc(misalign_exc), .exc_addr(exc_addr),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_sign_extend(dmem_sign_extend), .dmem_size(dmem_size),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    // DMEM model: little-endian byte store, one-cycle read latency, extension done here.
    logic [7:0]  mem [logic [31:0]];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic        last_sext = 1'b0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [1:0]  ws_q[$];

    function automatic logic [7:0] rdb(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (dmem_write) begin
            for (int i = 0; i < ((dmem_size == 2'b00) ? 1 : (dmem_size == 2'b01) ? 2 : 4); i++)
                mem[dmem_addr + 32'(i)] = dmem_wdata[8*i +: 8];
            wr_cnt++;
            wa_q.push_back(dmem_addr);
            wd_q.push_back(dmem_wdata);
            ws_q.push_back(dmem_size);
        end
        if (dmem_read) begin
            rd_cnt++;
            last_sext = dmem_sign_extend;
            case (dmem_size)
                2'b00:   dmem_rdata <= {{24{dmem_sign_extend & rdb(dmem_addr)[7]}}, rdb(dmem_addr)};
                2'b01:   dmem_rdata <= {{16{dmem_sign_extend & rdb(dmem_addr + 32'd1)[7]}},
                                        rdb(dmem_addr + 32'd1), rdb(dmem_addr)};
                default: dmem_rdata <= {rdb(dmem_addr + 32'd3), rdb(dmem_addr + 32'd2),
                                        rdb(dmem_addr + 32'd1), rdb(dmem_addr)};
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic any_out();
        return |{req_ready, resp_valid, resp_is_load, resp_rd, resp_data, misalign_exc,
                 exc_addr, dmem_read, dmem_write, dmem_sign_extend, dmem_size,
                 dmem_addr, dmem_wdata};
    endfunction

    int          lat;
    logic [31:0] r_data, r_eaddr;
    logic        r_exc, r_isload;
    logic [4:0]  r_rd;

    // Presents one request, then waits (bounded) for its response pulse.
    // lat counts edges from the accepting edge to the edge where resp_valid is sampled; 0 = timeout.
    task automatic do_req(input logic ld, input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1'b1; req_load = ld; req_store = st; req_size = sz;
        req_unsigned = un; req_addr = a; req_wdata = wd; req_rd = rd;
        tick();
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'h0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            if (resp_valid) begin
                lat = k; r_data = resp_data; r_eaddr = exc_addr;
                r_exc = misalign_exc; r_isload = resp_is_load; r_rd = resp_rd;
                break;
            end
            tick();
        end
    endtask

    int w0, r0, qb;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'h0;
        r_data = 32'h0; r_eaddr = 32'h0; r_exc = 1'b0; r_isload = 1'b0; r_rd = 5'h0;
        tick(); tick();
        chk("reset_outputs_zero", 32'(any_out()), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Aligned word store then load.
        qb = wa_q.size();
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd3);
        chk("sw_latency", 32'(lat), 32'd2);
        chk("sw_resp_data", r_data, 32'h0);
        chk("sw_is_load", 32'(r_isload), 32'd0);
        chk("sw_write_addr", (wa_q.size() == qb + 1) ? wa_q[qb] : 32'hX, 32'h100);
        chk("sw_write_data", (wd_q.size() == qb + 1) ? wd_q[qb] : 32'hX, 32'hDEADBEEF);
        chk("sw_write_size", (ws_q.size() == qb + 1) ? 32'(ws_q[qb]) : 32'hX, 32'd2);
        tick();
        chk("post_resp_valid_low", 32'(resp_valid), 32'd0);
        chk("post_resp_ready", 32'(req_ready), 32'd1);

        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd9);
        chk("lw_latency", 32'(lat), 32'd3);
        chk("lw_data", r_data, 32'hDEADBEEF);
        chk("lw_is_load", 32'(r_isload), 32'd1);
        chk("lw_rd", 32'(r_rd), 32'd9);
        tick();

        // Byte 0x80 at 0x103: signed and unsigned byte loads.
        do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h00000080, 5'd1);
        tick();
        do_req(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd4);
        chk("lb_data", r_data, 32'hFFFFFF80);
        chk("lb_sext", 32'(last_sext), 32'd1);
        tick();
        do_req(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd4);
        chk("lbu_data", r_data, 32'h00000080);
        chk("lbu_sext", 32'(last_sext), 32'd0);
        tick();
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd5);
        chk("lh_aligned_data", r_data, 32'hFFFF80AD);
        tick();
        do_req(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 5'd5);
        chk("lhu_aligned_data", r_data, 32'h000080AD);
        tick();

        // Valid with neither load nor store is ignored.
        w0 = wr_cnt; r0 = rd_cnt;
        req_valid = 1'b1; req_addr = 32'h100;
        tick(); tick(); tick();
        chk("ignored_no_resp", 32'(resp_valid), 32'd0);
        chk("ignored_ready", 32'(req_ready), 32'd1);
        chk("ignored_no_strobe", 32'(wr_cnt + rd_cnt), 32'(w0 + r0));
        req_valid = 1'b0;

        // Load and store both set: load wins, no write.
        w0 = wr_cnt;
        do_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 5'd2);
        chk("both_is_load", 32'(r_isload), 32'd1);
        chk("both_data", r_data, 32'h80ADBEEF);
        chk("both_no_write", 32'(wr_cnt), 32'(w0));
        tick();

`ifndef LSU_MISALIGN_SPLIT_EN
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 5'd7);
        chk("exc_lh_latency", 32'(lat), 32'd1);
        chk("exc_lh_flag", 32'(r_exc), 32'd1);
        chk("exc_lh_addr", r_eaddr, 32'h101);
        chk("exc_lh_rd", 32'(r_rd), 32'd7);
        chk("exc_lh_data", r_data, 32'h0);
        tick();
        do_req(1'b0, 1'b1, 2'b11, 1'b0, 32'h102, 32'hCAFEF00D, 5'd8);
        chk("exc_sw_latency", 32'(lat), 32'd1);
        chk("exc_sw_addr", r_eaddr, 32'h102);
        chk("exc_no_strobes", 32'(wr_cnt + rd_cnt), 32'(w0 + r0));
        tick();
`else
        qb = wa_q.size();
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h201, 32'h11223344, 5'd6);
        chk("split_sw_latency", 32'(lat), 32'd5);
        chk("split_sw_exc", 32'(r_exc), 32'd0);
        chk("split_sw_count", 32'(wa_q.size()), 32'(qb + 4));
        for (int i = 0; i < 4; i++) begin
            chk("split_sw_addr", (wa_q.size() > qb + i) ? wa_q[qb+i] : 32'hX, 32'h201 + 32'(i));
            chk("split_sw_data", (wd_q.size() > qb + i) ? wd_q[qb+i] : 32'hX,
                (i == 0) ? 32'h44 : (i == 1) ? 32'h33 : (i == 2) ? 32'h22 : 32'h11);
            chk("split_sw_size", (ws_q.size() > qb + i) ? 32'(ws_q[qb+i]) : 32'hX, 32'd0);
        end
        tick();
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h201, 32'h0, 5'd6);
        chk("split_lw_latency", 32'(lat), 32'd9);
        chk("split_lw_data", r_data, 32'h11223344);
        chk("split_lw_exc", 32'(r_exc), 32'd0);
        tick();
        do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h34, 5'd1);
        tick();
        do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 32'h85, 5'd1);
        tick();
        do_req(1'b1, 1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd11);
        chk("split_lh_wrap_latency", 32'(lat), 32'd5);
        chk("split_lh_wrap_data", r_data, 32'hFFFF8534);
        tick();
`endif

        // Reset while a load sits in WAIT.
        req_valid = 1'b1; req_load = 1'b1; req_size = 2'b10; req_addr = 32'h100; req_rd = 5'd12;
        tick();
        req_valid = 1'b0; req_load = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs_zero", 32'(any_out()), 32'd0);
        tick();
        chk("rst_held_outputs_zero", 32'(any_out()), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 32'(req_ready), 32'd1);
        tick();
        chk("rst_no_stale_resp", 32'(resp_valid), 32'd0);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd13);
        chk("rst_after_lw_latency", 32'(lat), 32'd3);
        chk("rst_after_lw_data", r_data, 32'h80ADBEEF);
        chk("rst_after_lw_rd", 32'(r_rd), 32'd13);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit that sits directly upstream of DMEM and is the only block that drives DMEM's ports.
- Accepts one memory request at a time from the EX stage over a valid/ready handshake.
- Checks natural alignment, sequences the DMEM access and returns one registered response pulse to write-back.
- Handles misaligned accesses as a precise exception, or as byte-serial access when the optional feature is compiled in.

Parameters:
- RD_W, 5, destination register tag width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  EX request valid.
- req_ready  out  1  LSU can accept a request.
- req_load  in  1  request is a load.
- req_store  in  1  request is a store.
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- req_unsigned  in  1  zero-extend load (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  RD_W  destination tag.
- resp_valid  out  1  one-cycle completion pulse.
- resp_is_load  out  1  completed request was a load.
- resp_rd  out  RD_W  tag of completed request.
- resp_data  out  32  extended load data; 0 for stores and exceptions.
- misalign_exc  out  1  valid with resp_valid; access was misaligned and not performed.
- exc_addr  out  32  faulting address when misalign_exc=1, else 0.
- dmem_read  out  1  DMEM mem_read.
- dmem_write  out  1  DMEM mem_write.
- dmem_sign_extend  out  1  DMEM sign_extend.
- dmem_size  out  2  DMEM size.
- dmem_addr  out  32  DMEM addr.
- dmem_wdata  out  32  DMEM write_data.
- dmem_rdata  in  32  DMEM read_data.

Behaviour:
- DMEM contract:
  - Writes commit on the posedge where dmem_write=1.
  - read_data is valid in the cycle after dmem_read=1.
  - DMEM extends loads per size/sign_extend.
  - Store data is right-aligned.
- Handshake:
  - A request is accepted on a posedge with req_valid & req_ready & (req_load|req_store).
  - req_valid with neither load nor store set is ignored.
  - If both are set, load wins.
  - All request fields are latched at acceptance.
- req_ready=1 only in IDLE and only while rst=0. There is no response backpressure.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]!=0. Byte accesses are never misaligned.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: on accept, aligned requests go to ISSUE; misaligned requests go to DONE with exception.
  - ISSUE: drive dmem_read or dmem_write for exactly one cycle, with dmem_addr/size/wdata from the latched request and dmem_sign_extend = ~unsigned. Store goes to DONE; load goes to WAIT.
  - WAIT: no DMEM strobes. Capture dmem_rdata into the response register, then go to DONE.
  - DONE: resp_valid=1 for one cycle with latched rd and is_load, then go to IDLE.
- Latency (accept at cycle T):
  - Aligned store: resp_valid at T+2.
  - Aligned load: resp_valid at T+3.
  - Misaligned exception: resp_valid at T+1.
  - Next accept possible one cycle after DONE.
- Exception response: no DMEM strobe is issued for the faulting request. resp_data=0, misalign_exc=1, exc_addr=latched addr.
- dmem_* outputs are 0 in every state other than ISSUE.
- Reset (including mid-operation):
  - Next state is IDLE; any in-flight request is discarded and gets no response.
  - All outputs are 0: resp_*, misalign_exc, exc_addr, dmem_*, req_ready.
  - A store already committed in ISSUE is not undone.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Without the macro: behaviour exactly as above (misaligned requests raise an exception).
- With the macro: misaligned requests never raise misalign_exc. They are executed as N byte accesses (N=2 half, 4 word) using a 2-bit byte index idx=0..N-1.
  - Each byte access sets dmem_addr = addr+idx (modulo 2^32, so 0xFFFFFFFF+1 = 0x00000000) and dmem_size=00.
  - Loads: each byte is ISSUE then WAIT, with dmem_sign_extend=0. Byte dmem_rdata[7:0] goes into lane idx. After the last byte, the result is sign- or zero-extended from bit 15 (half) or is already full (word).
  - Stores: N consecutive ISSUE cycles, each with dmem_wdata = {24'b0, req_wdata[8*idx+7 -: 8]}.
  - Split latency: load resp at T+2N+1; store resp at T+N+1.
  - Reset mid-split aborts; bytes already stored remain.

Test Plan:
- Aligned SW addr=0x100 data=0xDEADBEEF, then LW 0x100 -> store resp at T+2 with resp_data=0; load resp at T+3 with resp_data=0xDEADBEEF.
- LB 0x103 with DMEM byte 0x80 -> 0xFFFFFF80; LBU 0x103 -> 0x00000080. dmem_sign_extend must be 1 for LB and 0 for LBU.
- Macro off: LH addr=0x101 rd=7 -> resp at T+1 with misalign_exc=1, exc_addr=0x101, resp_rd=7; dmem_read/dmem_write never asserted.
- Macro on: SW 0x201 data=0x11223344, then LW 0x201 -> four byte writes 0x44,0x33,0x22,0x11 to 0x201..0x204; load returns 0x11223344 at T+9; misalign_exc stays 0.
- Macro on: LH addr=0xFFFFFFFF with byte[0xFFFFFFFF]=0x34, byte[0x0]=0x85 -> second access goes to dmem_addr=0; resp_data=0xFFFF8534.
- Reset asserted in WAIT of a load -> no resp_valid; all outputs 0 during reset; req_ready=1 the cycle after rst deasserts; a following LW completes normally.
